// File: rtl/video_timing.sv
// video_timing: raster counters, pipeline-aligned hs/vs/de and the CPU vblank interrupt.
module video_timing #(
  parameter int VIDEO_WIDE = 0,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 80,
  parameter int H_BP       = 104,
  parameter int V_ACTIVE   = 576,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 7,
  parameter int V_BP       = 17,
  parameter bit SYNC_POS   = 1'b0,
  parameter int PIPE_DELAY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_en_wr,
  input  logic        irq_en_din,
  input  logic        irq_ack,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        irq,
  output logic [7:0]  frame
);
  localparam int H_ACTIVE = (VIDEO_WIDE != 0) ? 1024 : 768;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  IDLE   = {~SYNC_POS, ~SYNC_POS, 1'b0};
  generate
    if (H_TOTAL > 2048 || V_TOTAL > 1024 || PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_params
      $error("video_timing: illegal timing parameters");
    end
  endgenerate
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [7:0]  frame_q, frame_d;
  logic        irq_q, irq_d, irq_en_q, irq_en_d;
  logic [PIPE_DELAY:0][2:0] pipe_q, pipe_d;
  logic        h_end, v_end, hs_raw, vs_raw, de_raw, vblank;
  always_comb begin
    h_end    = x_q == 11'(H_TOTAL - 1);
    v_end    = y_q == 10'(V_TOTAL - 1);
    x_d      = h_end ? '0 : x_q + 11'd1;
    y_d      = h_end ? (v_end ? '0 : y_q + 10'd1) : y_q;
    frame_d  = frame_q + {7'd0, h_end && v_end};
    de_raw   = (x_q < 11'(H_ACTIVE)) && (y_q < 10'(V_ACTIVE));
    hs_raw   = ({1'b0, x_q} >= HS_ON) && ({1'b0, x_q} < HS_OFF);
    vs_raw   = ({1'b0, y_q} >= VS_ON) && ({1'b0, y_q} < VS_OFF);
    vblank   = (x_q == '0) && (y_q == 10'(V_ACTIVE));
    irq_en_d = irq_en_wr ? irq_en_din : irq_en_q;
    // a set in the same cycle as an ack wins; disabling in the same cycle suppresses the set
    irq_d    = (vblank && irq_en_d) ? 1'b1 : (irq_ack || (irq_en_wr && !irq_en_din)) ? 1'b0 : irq_q;
    pipe_d    = pipe_q;
    pipe_d[0] = {SYNC_POS ? hs_raw : !hs_raw, SYNC_POS ? vs_raw : !vs_raw, de_raw};
    for (int i = 1; i <= PIPE_DELAY; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      frame_q  <= '0;
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
      pipe_q   <= {(PIPE_DELAY + 1){IDLE}};
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      frame_q  <= frame_d;
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
      pipe_q   <= pipe_d;
    end
  end
  assign x     = x_q;
  assign y     = y_q;
  assign frame = frame_q;
  assign irq   = irq_q;
  assign hs    = pipe_q[PIPE_DELAY][2];
  assign vs    = pipe_q[PIPE_DELAY][1];
  assign de    = pipe_q[PIPE_DELAY][0];
endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: directed checks of default, short-frame and wide/no-delay configurations.
module tb_video_timing;
  logic clk = 1'b0, reset = 1'b1, irq_en_wr = 1'b0, irq_en_din = 1'b0, irq_ack = 1'b0;
  always #5 clk = ~clk;
  logic [10:0] a_x, b_x, c_x;
  logic [9:0]  a_y, b_y, c_y;
  logic        a_hs, a_vs, a_de, a_irq, b_hs, b_vs, b_de, b_irq, c_hs, c_vs, c_de, c_irq;
  logic [7:0]  a_frame, b_frame, c_frame;
  int checks = 0, errors = 0;
  int sb[$];
  int n, m;
  video_timing dut_a (
    .clk(clk), .reset(reset), .irq_en_wr(irq_en_wr), .irq_en_din(irq_en_din), .irq_ack(irq_ack),
    .x(a_x), .y(a_y), .hs(a_hs), .vs(a_vs), .de(a_de), .irq(a_irq), .frame(a_frame));
  // short frame: H_TOTAL 780, V_TOTAL 6, vblank at line 2, vsync on lines 3..4
  video_timing #(.H_FP(4), .H_SYNC(4), .H_BP(4), .V_ACTIVE(2), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_b (
    .clk(clk), .reset(reset), .irq_en_wr(irq_en_wr), .irq_en_din(irq_en_din), .irq_ack(irq_ack),
    .x(b_x), .y(b_y), .hs(b_hs), .vs(b_vs), .de(b_de), .irq(b_irq), .frame(b_frame));
  video_timing #(.VIDEO_WIDE(1), .PIPE_DELAY(0)) dut_c (
    .clk(clk), .reset(reset), .irq_en_wr(irq_en_wr), .irq_en_din(irq_en_din), .irq_ack(irq_ack),
    .x(c_x), .y(c_y), .hs(c_hs), .vs(c_vs), .de(c_de), .irq(c_irq), .frame(c_frame));
  task automatic tick(int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic want(int v);
    sb.push_back(v);
  endtask
  task automatic chk(string tag, int obs);
    int e;
    e = (sb.size() == 0) ? -1 : sb.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, e);
    end
  endtask
  task automatic wait_a_x(int xx, string tag);
    int k = 0;
    while (int'(a_x) != xx && k < 3000) begin tick(); k++; end
    want(1); chk(tag, int'(k < 3000));
  endtask
  task automatic wait_b(int yy, int xx, string tag);
    int k = 0;
    while ((int'(b_y) != yy || int'(b_x) != xx) && k < 6000) begin tick(); k++; end
    want(1); chk(tag, int'(k < 6000));
  endtask
  task automatic wait_c_x(int xx, string tag);
    int k = 0;
    while (int'(c_x) != xx && k < 3000) begin tick(); k++; end
    want(1); chk(tag, int'(k < 3000));
  endtask
  initial begin
    tick(3);
    reset = 1'b0;
    wait_a_x(500, "reach_x500");
    reset = 1'b1;
    want(0); want(0); want(0); want(0); want(0); want(1); want(1); want(0);
    tick(5);
    chk("rst_x", a_x); chk("rst_y", a_y); chk("rst_frame", a_frame); chk("rst_irq", a_irq);
    chk("rst_de", a_de); chk("rst_hs", a_hs); chk("rst_vs", a_vs); chk("rst_b_irq", b_irq);
    reset = 1'b0;
    want(1); tick(); chk("x_after_rst", a_x);
    want(0); tick(2); chk("de_before_rise", a_de);
    want(1); tick(); chk("de_rise", a_de);
    wait_a_x(792, "reach_x792");
    n = 0;
    do begin tick(); n++; end while (a_hs && n < 100);
    want(4); chk("hs_delay", n);
    m = 0;
    while (!a_hs && m < 2000) begin tick(); m++; end
    want(80); chk("hs_width", m);
    wait_a_x(975, "reach_x975");
    want(0); chk("y_pre_wrap", a_y);
    want(0); want(1); tick(); chk("x_wrap", a_x); chk("y_inc", a_y);
    n = 0;
    while (!a_de && n < 100) begin tick(); n++; end
    want(4); chk("de_delay_line1", n);
    m = 0;
    while (a_de && m < 2000) begin tick(); m++; end
    want(768); chk("de_width", m);
    wait_b(3, 0, "b_reach_vs_line");
    n = 0;
    while (b_vs && n < 100) begin tick(); n++; end
    want(4); chk("vs_delay", n);
    m = 0;
    while (!b_vs && m < 5000) begin tick(); m++; end
    want(2 * 780); chk("vs_width", m);
    wait_b(5, 779, "b_reach_frame_end");
    want(0); chk("frame_before", b_frame);
    want(0); want(0); want(1);
    tick(); chk("b_x_wrap", b_x); chk("b_y_wrap", b_y); chk("frame_inc", b_frame);
    m = 0;
    for (int i = 0; i < 6 * 780; i++) begin tick(); m += int'(b_de); end
    want(2 * 768); chk("de_per_frame", m);
    want(2); chk("frame_two", b_frame);
    irq_en_wr = 1'b1; irq_en_din = 1'b1; tick(); irq_en_wr = 1'b0;
    wait_b(2, 0, "b_vblank1");
    want(0); chk("irq_pre", b_irq);
    want(1); tick(); chk("irq_set", b_irq);
    irq_ack = 1'b1; want(0); tick(); irq_ack = 1'b0; chk("irq_ack_clears", b_irq);
    irq_en_wr = 1'b1; irq_en_din = 1'b0; tick(); irq_en_wr = 1'b0;
    wait_b(2, 0, "b_vblank2");
    want(0); tick(2); chk("irq_disabled", b_irq);
    irq_en_wr = 1'b1; irq_en_din = 1'b1; tick(); irq_en_wr = 1'b0;
    wait_b(2, 0, "b_vblank3");
    irq_ack = 1'b1; want(1); tick(); irq_ack = 1'b0; chk("set_beats_ack", b_irq);
    want(1); tick(6 * 780); chk("irq_persists", b_irq);
    irq_en_wr = 1'b1; irq_en_din = 1'b0; want(0); tick(); irq_en_wr = 1'b0; chk("en0_clears", b_irq);
    wait_b(2, 0, "b_vblank4");
    irq_en_wr = 1'b1; irq_en_din = 1'b1; want(1); tick(); irq_en_wr = 1'b0; chk("set_with_en_write", b_irq);
    irq_ack = 1'b1; want(0); tick(); irq_ack = 1'b0; chk("ack_again", b_irq);
    wait_b(2, 0, "b_vblank5");
    irq_en_wr = 1'b1; irq_en_din = 1'b0; want(0); tick(); irq_en_wr = 1'b0; chk("set_vs_en0", b_irq);
    wait_c_x(1231, "c_reach_x1231");
    want(0); tick(); chk("c_x_wrap", c_x);
    n = 0;
    while (!c_de && n < 10) begin tick(); n++; end
    want(1); chk("c_de_delay", n);
    m = 0;
    while (c_de && m < 2000) begin tick(); m++; end
    want(1024); chk("c_de_width", m);
    n = 0;
    while (c_x != 11'd0 && n < 2000) begin tick(); n++; end
    want(207); chk("c_line_tail", n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
